// File: rtl/pad_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pad_sched_pkg
// Brief    : Shared types and helpers for the padding layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pad_sched_pkg;

    localparam int unsigned PE_DEFAULT = 16;
    localparam int unsigned LOG2_PE    = $clog2(PE_DEFAULT);

    typedef struct packed {
        logic [7:0] c;
        logic [7:0] w;
        logic       pad;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // A row must split into whole beats: c*w has to be a multiple of the lane count.
    function automatic logic desc_legal(input desc_t d, input int unsigned lg);
        logic [15:0] prod;
        logic [15:0] mask;
        prod = 16'(d.c) * 16'(d.w);
        mask = 16'((32'd1 << lg) - 32'd1);
        return (d.c != 8'd0) && (d.w != 8'd0) && ((prod & mask) == 16'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_layer_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : pad_layer_sched_if
// Brief    : Descriptor, producer, engine and status signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pad_layer_sched_if;

    logic        desc_valid;
    logic        desc_ready;
    logic [7:0]  desc_c;
    logic [7:0]  desc_w;
    logic        desc_pad;
    logic        prod_valid;
    logic        prod_ready;
    logic        pad_start;
    logic        pad_valid;
    logic [7:0]  cfg_ofm_c;
    logic [7:0]  cfg_ofm_w;
    logic        cfg_padding;
    logic        bank_sel;
    logic [31:0] bank_base;
    logic        layer_done;
    logic        busy;
    logic        err_cfg;
    logic [15:0] layer_cnt;

    modport master (
        output desc_valid, desc_c, desc_w, desc_pad, prod_valid,
        input  desc_ready, prod_ready, pad_start, pad_valid, cfg_ofm_c, cfg_ofm_w,
               cfg_padding, bank_sel, bank_base, layer_done, busy, err_cfg, layer_cnt
    );

    modport slave (
        input  desc_valid, desc_c, desc_w, desc_pad, prod_valid,
        output desc_ready, prod_ready, pad_start, pad_valid, cfg_ofm_c, cfg_ofm_w,
               cfg_padding, bank_sel, bank_base, layer_done, busy, err_cfg, layer_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pad_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pad_desc_fifo
// Brief    : Small synchronous FIFO of layer descriptors, head visible combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module pad_desc_fifo
    import pad_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  push,
    input  wire desc_t push_data,
    input  wire logic  pop,
    output logic       full,
    output logic       empty,
    output desc_t      head
);

    localparam int c_aw = $clog2(DEPTH);

    desc_t          r_mem [DEPTH];
    logic [c_aw:0]  r_wr_ptr;
    logic [c_aw:0]  r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign head  = r_mem[r_rd_ptr[c_aw-1:0]];

    // A simultaneous pop frees the slot, so a full FIFO may still take a push.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pad_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : pad_layer_sched
// Brief    : Per-layer sequencer for the padding write engine with bank ping-pong.
// Revision : 1.0 - initial release
// ============================================================================
module pad_layer_sched
    import pad_sched_pkg::*;
#(
    parameter int          PE          = 16,
    parameter int          DESC_DEPTH  = 4,
    parameter logic [31:0] BANK_OFFSET = 32'h0000_8000,
    parameter int          DRAIN_EXTRA = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pad_layer_sched_if.slave   bus
);

    localparam int unsigned c_log2_pe = $clog2(PE);

    state_t      r_state;
    state_t      w_state_nxt;
    desc_t       w_desc_in;
    desc_t       w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_legal;
    logic        w_push;
    logic        w_pop;
    logic        w_pad_start;
    logic        w_prod_ready;
    logic        w_pad_valid;
    logic [31:0] w_prod;
    logic [31:0] w_row_beats;
    logic [31:0] w_total_beats;
    logic [31:0] w_drain_cycles;
    logic [31:0] r_total_beats;
    logic [31:0] r_beat_cnt;
    logic [31:0] r_drain_cnt;
    logic [7:0]  r_cfg_c;
    logic [7:0]  r_cfg_w;
    logic        r_cfg_pad;
    logic        r_bank_sel;
    logic        r_layer_done;
    logic        r_err_cfg;
    logic [15:0] r_layer_cnt;

    assign w_desc_in = '{c: bus.desc_c, w: bus.desc_w, pad: bus.desc_pad};
    assign w_accept  = bus.desc_valid && !w_full;
    assign w_legal   = desc_legal(w_desc_in, c_log2_pe);
    assign w_push    = w_accept && w_legal;

    pad_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_desc_in),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Layer geometry from the FIFO head, captured in LOAD at full 32-bit width.
    assign w_prod         = 32'(w_head.c) * 32'(w_head.w);
    assign w_row_beats    = w_prod >> c_log2_pe;
    assign w_total_beats  = 32'(w_head.w) * w_row_beats;
    assign w_drain_cycles = w_head.pad
        ? ((32'(w_head.c) * (32'(w_head.w) + 32'd2)) >> c_log2_pe) + 32'(DRAIN_EXTRA)
        : 32'(DRAIN_EXTRA);

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_pad_start  = 1'b0;
        w_prod_ready = 1'b0;
        w_pad_valid  = 1'b0;
        case (r_state)
            IDLE:  if (!w_empty) w_state_nxt = LOAD;
            LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = START;
            end
            START: begin
                w_pad_start = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_prod_ready = 1'b1;
                w_pad_valid  = bus.prod_valid;
                if (bus.prod_valid && (r_beat_cnt + 32'd1 == r_total_beats))
                    w_state_nxt = DRAIN;
            end
            DRAIN: if (r_drain_cnt <= 32'd1) w_state_nxt = DONE;
            DONE:  w_state_nxt = w_empty ? IDLE : LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_total_beats <= '0;
            r_beat_cnt    <= '0;
            r_drain_cnt   <= '0;
            r_cfg_c       <= '0;
            r_cfg_w       <= '0;
            r_cfg_pad     <= 1'b0;
            r_bank_sel    <= 1'b0;
            r_layer_done  <= 1'b0;
            r_err_cfg     <= 1'b0;
            r_layer_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_layer_done <= 1'b0;
            if (w_accept && !w_legal) r_err_cfg <= 1'b1;
            case (r_state)
                LOAD: begin
                    r_cfg_c       <= w_head.c;
                    r_cfg_w       <= w_head.w;
                    r_cfg_pad     <= w_head.pad;
                    r_total_beats <= w_total_beats;
                    r_drain_cnt   <= w_drain_cycles;
                    r_beat_cnt    <= '0;
                end
                RUN:   if (bus.prod_valid) r_beat_cnt <= r_beat_cnt + 32'd1;
                DRAIN: if (r_drain_cnt > 32'd1) r_drain_cnt <= r_drain_cnt - 32'd1;
                DONE: begin
                    r_layer_done <= 1'b1;
                    r_bank_sel   <= ~r_bank_sel;
                    r_layer_cnt  <= r_layer_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.desc_ready  = !w_full;
    assign bus.prod_ready  = w_prod_ready;
    assign bus.pad_start   = w_pad_start;
    assign bus.pad_valid   = w_pad_valid;
    assign bus.cfg_ofm_c   = r_cfg_c;
    assign bus.cfg_ofm_w   = r_cfg_w;
    assign bus.cfg_padding = r_cfg_pad;
    assign bus.bank_sel    = r_bank_sel;
    assign bus.bank_base   = r_bank_sel ? BANK_OFFSET : 32'd0;
    assign bus.layer_done  = r_layer_done;
    assign bus.busy        = (r_state != IDLE);
    assign bus.err_cfg     = r_err_cfg;
    assign bus.layer_cnt   = r_layer_cnt;

endmodule
`default_nettype wire
